// File: rtl/hamming_decode_pipe.sv
// Two-stage Hamming(38,32) decoder with valid/ready flow control and
// saturating counters of corrected and uncorrectable words delivered downstream.
module hamming_decode_pipe #(
  parameter int CORRECT_EN = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [37:0]      in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [5:0]       out_syndrome,
  output logic             out_err_corr,
  output logic             out_err_uncorr,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam int DATA_W = 32;
  localparam int CODE_W = 38;

  // Syndrome is the XOR of the 1-based positions of every set bit.
  function automatic logic [5:0] calc_syndrome(input logic [CODE_W-1:0] code);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (code[i]) s = s ^ 6'(i + 1);
    end
    return s;
  endfunction

  // Data bits live at every position that is not a power of two.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    logic [4:0]        k;
    d = '0;
    k = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (((i + 1) & i) != 0) begin
        d[k] = code[i];
        k    = k + 5'd1;
      end
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic              s1_adv, s2_adv, out_hs;
  logic              vld_p1_q;
  logic [CODE_W-1:0] code_p1_q;
  logic [5:0]        syn_p1_q;
  logic              vld_p2_q, corr_p2_q, uncorr_p2_q;
  logic [DATA_W-1:0] data_p2_q;
  logic [5:0]        syn_p2_q;
  logic [CNT_W-1:0]  corr_cnt_q, uncorr_cnt_q;

  logic              corr_p2_d, uncorr_p2_d;
  logic [CODE_W-1:0] fixed_p2_d;
  logic [DATA_W-1:0] data_p2_d;

  assign s2_adv   = !vld_p2_q || out_ready;
  assign s1_adv   = !vld_p1_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = vld_p2_q && out_ready;

  // ---- stage 1: capture codeword and its syndrome ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      code_p1_q <= '0;
      syn_p1_q  <= '0;
    end else if (s1_adv) begin
      vld_p1_q  <= in_valid;
      code_p1_q <= in_code;
      syn_p1_q  <= calc_syndrome(in_code);
    end
  end

  always_comb begin
    corr_p2_d   = (syn_p1_q != 6'd0) && (syn_p1_q <= 6'd38);
    uncorr_p2_d = (syn_p1_q >= 6'd39);
    fixed_p2_d  = code_p1_q;
    if ((CORRECT_EN != 0) && corr_p2_d) begin
      fixed_p2_d = code_p1_q ^ (CODE_W'(1) << (syn_p1_q - 6'd1));
    end
    data_p2_d = extract_data(fixed_p2_d);
  end

  // ---- stage 2: corrected data and error flags ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q    <= 1'b0;
      data_p2_q   <= '0;
      syn_p2_q    <= '0;
      corr_p2_q   <= 1'b0;
      uncorr_p2_q <= 1'b0;
    end else if (s2_adv) begin
      vld_p2_q    <= vld_p1_q;
      data_p2_q   <= data_p2_d;
      syn_p2_q    <= syn_p1_q;
      corr_p2_q   <= corr_p2_d;
      uncorr_p2_q <= uncorr_p2_d;
    end
  end

  // Counters only see words actually taken by the consumer.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (out_hs) begin
      if (corr_p2_q)   corr_cnt_q   <= sat_inc(corr_cnt_q);
      if (uncorr_p2_q) uncorr_cnt_q <= sat_inc(uncorr_cnt_q);
    end
  end

  assign out_valid      = vld_p2_q;
  assign out_data       = data_p2_q;
  assign out_syndrome   = syn_p2_q;
  assign out_err_corr   = corr_p2_q;
  assign out_err_uncorr = uncorr_p2_q;
  assign corr_cnt       = corr_cnt_q;
  assign uncorr_cnt     = uncorr_cnt_q;

endmodule
